// File: rtl/debounce_sync_variable_width_pkg.sv
// Shared constants and helpers for the
// debounce_sync_variable_width input conditioner.
package debounce_sync_variable_width_pkg;

  localparam int unsigned DefWidth = 1;
  localparam int unsigned DefCount = 4;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(
    input int unsigned v
  );
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, v}) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_sync_variable_width_bit.sv
// Single-bit conditioner: 2-flop synchroniser,
// saturating debounce counter and output flop.
module debounce_bit
  import debounce_sync_variable_width_pkg::*;
#(
  parameter int unsigned Debounce_Count = DefCount
) (
  input  logic clk,
  input  logic sres,
  input  logic ld_en,
  input  logic raw,
  output logic level,
  output logic busy
);

  localparam int unsigned Count_Bits =
    clog2(Debounce_Count + 1);
  localparam logic [Count_Bits-1:0] Last =
    Count_Bits'(Debounce_Count - 1);
  localparam logic [Count_Bits-1:0] One =
    Count_Bits'(1);

  logic                  sync1;
  logic                  sync2;
  logic [Count_Bits-1:0] count;

  // Free-running synchroniser, independent of ld_en.
  always_ff @(posedge clk) begin
    if (sres) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count enabled mismatching samples; any match restarts.
  always_ff @(posedge clk) begin
    if (sres) begin
      count <= '0;
      level <= 1'b0;
    end else if (ld_en) begin
      if (sync2 == level) begin
        count <= '0;
      end else if (count == Last) begin
        level <= sync2;
        count <= '0;
      end else begin
        count <= count + One;
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/debounce_sync_variable_width.sv
// Width-parallel debounce/synchroniser; each bit
// is an independent debounce_bit instance.
module debounce_sync_variable_width
  import debounce_sync_variable_width_pkg::*;
#(
  parameter int unsigned Width          = DefWidth,
  parameter int unsigned Debounce_Count = DefCount
) (
  input  logic             clk,
  input  logic             sres,
  input  logic             ld_en,
  input  logic [Width-1:0] Level_In,
  output logic [Width-1:0] Level_Out,
  output logic [Width-1:0] Busy
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    debounce_bit #(
      .Debounce_Count(Debounce_Count)
    ) u_bit (
      .clk  (clk),
      .sres (sres),
      .ld_en(ld_en),
      .raw  (Level_In[i]),
      .level(Level_Out[i]),
      .busy (Busy[i])
    );
  end

endmodule

// File: tb/tb_debounce_sync_variable_width.sv
// Bench for debounce_sync_variable_width: vector
// table, corner sequences and random vs. model.
module tb_debounce_sync_variable_width;

  logic       clk = 1'b0;
  logic       sres;
  logic       ld_en;
  logic [3:0] lin;
  logic [3:0] oa, ba, ob, bb;

  always #5 clk = ~clk;

  debounce_sync_variable_width #(
    .Width(4), .Debounce_Count(4)
  ) u_a (
    .clk(clk), .sres(sres), .ld_en(ld_en),
    .Level_In(lin), .Level_Out(oa), .Busy(ba)
  );

  debounce_sync_variable_width #(
    .Width(4), .Debounce_Count(1)
  ) u_b (
    .clk(clk), .sres(sres), .ld_en(ld_en),
    .Level_In(lin), .Level_Out(ob), .Busy(bb)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: sync is a 2-deep delay line;
  // per bit, the enabled samples since the last
  // output change or reset are kept in a queue, and
  // the output flips once the newest N of them all
  // differ from it.
  logic [3:0] ms1 [2];
  logic [3:0] ms2 [2];
  logic [3:0] mo  [2];
  logic [3:0] mb  [2];
  bit         hq  [2][4][$];
  int         mn  [2] = '{4, 1};

  function automatic int trail(int d, int i);
    int n;
    n = 0;
    for (int j = hq[d][i].size() - 1; j >= 0; j--) begin
      if (hq[d][i][j] == mo[d][i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (sres) begin
        ms1[d] = '0;
        ms2[d] = '0;
        mo[d]  = '0;
        mb[d]  = '0;
        for (int i = 0; i < 4; i++) hq[d][i].delete();
      end else begin
        if (ld_en) begin
          for (int i = 0; i < 4; i++) begin
            hq[d][i].push_back(ms2[d][i]);
            if (trail(d, i) == mn[d]) begin
              mo[d][i] = ~mo[d][i];
              hq[d][i].delete();
            end
            mb[d][i] = (trail(d, i) > 0);
          end
        end
        ms2[d] = ms1[d];
        ms1[d] = lin;
      end
    end
  endtask

  task automatic cmp(
    input string      nm,
    input logic [3:0] act,
    input logic [3:0] exp
  );
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b",
               nm, act, exp);
    end
  endtask

  task automatic step(
    input bit         r,
    input bit         e,
    input logic [3:0] v
  );
    sres  = r;
    ld_en = e;
    lin   = v;
    @(posedge clk);
    model_edge();
    #1;
    cmp("mdl_a_out",  oa, mo[0]);
    cmp("mdl_a_busy", ba, mb[0]);
    cmp("mdl_b_out",  ob, mo[1]);
    cmp("mdl_b_busy", bb, mb[1]);
  endtask

  typedef struct {
    bit         r;
    bit         e;
    logic [3:0] v;
    logic [3:0] eo;
    logic [3:0] eb;
  } vec_t;

  vec_t tv [8];
  bit   pat [12];
  logic [3:0] v;

  initial begin
    for (int d = 0; d < 2; d++) begin
      ms1[d] = '0; ms2[d] = '0;
      mo[d]  = '0; mb[d]  = '0;
    end
    sres = 1'b1; ld_en = 1'b0; lin = '0;

    // Basic latency, N=4, bit0 set before edge 0.
    tv[0] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
    tv[1] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0};
    tv[2] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h0};
    tv[3] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h1};
    tv[4] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h1};
    tv[5] = '{1'b0, 1'b1, 4'h1, 4'h0, 4'h1};
    tv[6] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0};
    tv[7] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0};
    for (int k = 0; k < 8; k++) begin
      step(tv[k].r, tv[k].e, tv[k].v);
      cmp($sformatf("tbl%0d_out", k), oa, tv[k].eo);
      cmp($sformatf("tbl%0d_busy", k), ba, tv[k].eb);
    end

    // Bounce: high 3, low 1, then steady high.
    step(1, 1, 4'h0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, (k == 3) ? 4'h0 : 4'h1);
      cmp($sformatf("bounce%0d", k),
          {3'b0, oa[0]}, {3'b0, k >= 9});
    end

    // Enable gating: ld_en every 4th cycle.
    step(1, 1, 4'h0);
    for (int k = 0; k < 20; k++) begin
      step(0, (k % 4) == 3, 4'h1);
      cmp($sformatf("gate%0d", k),
          {3'b0, oa[0]}, {3'b0, k >= 15});
    end

    // Reset mid-count restarts full latency.
    step(1, 1, 4'h0);
    for (int k = 0; k < 4; k++) step(0, 1, 4'h1);
    cmp("mid_busy", {3'b0, ba[0]}, 4'h1);
    step(1, 1, 4'h1);
    cmp("rst_out", oa, 4'h0);
    cmp("rst_busy", ba, 4'h0);
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 4'h1);
      cmp($sformatf("rel%0d_out", k),
          {3'b0, oa[0]}, {3'b0, k >= 5});
      cmp($sformatf("rel%0d_busy", k),
          {3'b0, ba[0]}, {3'b0, k >= 2 && k <= 4});
    end

    // Independent bits; bit0 chatters every cycle.
    step(1, 1, 4'h0);
    for (int k = 0; k < 10; k++) begin
      v = 4'b1010 | {3'b0, k[0]};
      step(0, 1, v);
      cmp($sformatf("indep%0d", k), oa,
          (k >= 5) ? 4'b1010 : 4'b0000);
    end

    // N=1 instance follows input two edges late.
    for (int k = 0; k < 12; k++) pat[k] = (k >= 3 && k < 6);
    step(1, 1, 4'h0);
    for (int k = 0; k < 12; k++) begin
      step(0, 1, {3'b0, pat[k]});
      cmp($sformatf("n1_%0d", k), {3'b0, ob[0]},
          {3'b0, (k >= 2) ? pat[k-2] : 1'b0});
    end

    // Random stimulus against the model.
    step(1, 1, 4'h0);
    v = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
      end
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/debounce_sync_variable_width.md
Name: debounce_sync_variable_width

Overview:
- Per-bit input conditioner that sits directly upstream of the leading-edge pulse detector.
- Takes raw asynchronous or bouncing level inputs, such as switches or external strobes, and synchronises them into clk with a two-flop chain.
- Debounces each bit with an independent saturating sample counter.
- Level_Out is a clean, glitch-free level suitable for driving the detector's Level_In directly.

Parameters:
- Width, 1, number of independent input bits.
- Debounce_Count, 4, consecutive enabled samples of a new value required before Level_Out follows; legal range 1..65535.
- Count_Bits, derived localparam = clog2(Debounce_Count+1), counter width; not user-set.

Ports:
- clk  input  1  rising-edge clock.
- sres  input  1  synchronous reset, active-high; overrides ld_en.
- ld_en  input  1  sample enable (e.g. 1 kHz tick); debounce counters and Level_Out update only when high.
- Level_In  input  Width  raw asynchronous levels.
- Level_Out  output  Width  debounced synchronised levels.
- Busy  output  Width  per bit: counter nonzero, meaning a change is pending.

Behaviour:
- Reset (sres=1 at an edge):
  - sync stage 1, sync stage 2, every counter, Level_Out and Busy all clear to 0 on that edge.
  - Reset mid-count discards the pending change.
- Synchroniser:
  - Runs every edge and ignores ld_en (sync1 <= Level_In; sync2 <= sync1).
  - Only sync2 is used downstream.
- Per bit i, at each edge with sres=0 and ld_en=1:
  - sync2[i]==Level_Out[i]: counter <= 0.
  - sync2[i]!=Level_Out[i] and counter < Debounce_Count-1: counter <= counter+1.
  - sync2[i]!=Level_Out[i] and counter == Debounce_Count-1: Level_Out[i] <= sync2[i] and counter <= 0.
- ld_en=0: counters and Level_Out hold. A mismatch arising while disabled is not counted.
- Busy[i] = (counter[i] != 0), registered through the counter with no extra delay.
- Latency with ld_en held 1:
  - Level_In stable from before edge k gives a Level_Out change at edge k+1+Debounce_Count.
  - Debounce_Count=4: set before edge 0, Level_Out high after edge 5.
- Bounce: any enabled sample that matches Level_Out before the count completes clears the counter. A pulse shorter than Debounce_Count enabled samples never reaches Level_Out.
- Debounce_Count=1: Level_Out follows sync2 on the first enabled mismatching sample, with no counting.
- Counter never exceeds Debounce_Count-1; no wrap-around.
- Bits are fully independent; simultaneous changes on several bits resolve per bit.
- Level_Out is a pure register output with no combinational path from Level_In.

Decomposition:
- No shared package needed. Count_Bits is a local derived constant; the only shared item is a clog2 function if the team library already provides one.
- One sub-module: debounce_bit. It holds the 2-flop synchroniser, the counter and the output flop for a single bit, with Debounce_Count as a parameter.
- The top level instantiates debounce_bit Width times in a generate loop and concatenates Level_Out and Busy.

Test Plan:
1. Width=1, Debounce_Count=4, ld_en=1, apply sres then raise Level_In before edge 0 → Level_Out=0 through edge 4, =1 after edge 5; Busy=1 after edges 2..4, 0 after edge 5.
2. Bounce: Level_In high for 3 cycles, low 1, high steady (ld_en=1, N=4) → first burst never propagates; Level_Out rises 5 edges after the final rise.
3. Enable gating: ld_en pulses every 4th cycle, Level_In steps 0→1 → Level_Out rises on the 4th enabled edge after sync2 goes high, never between enables.
4. Reset mid-count: counter at 2 with Busy=1, assert sres one edge → Level_Out=0, Busy=0, and the full 1+N edge latency restarts after release.
5. Width=4, Level_In 0000→1010 then bit0 toggling each cycle → Level_Out=1010 after 5 edges; bit0 stays 0 throughout; bits are independent.
6. Debounce_Count=1, ld_en=1, Level_In 0→1→0 each held 3 cycles → Level_Out mirrors Level_In delayed 2 edges.
